// File: rtl/lsu.sv
// Load/store unit: one outstanding 32-bit access, lane-aligned stores, sign/zero-extended loads.
// Latency: accept -> REQ -> WAIT -> DONE, result visible three cycles after acceptance at best.
// Backpressure: in_ready only in IDLE; request and result held stable until their ready is seen.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] exu_data,
  input  logic [31:0] store_data,
  input  logic [3:0]  lsu_op,
  input  logic [4:0]  rd_in,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        err_q, err_d;

  logic        accept;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  assign accept = in_valid && (state_q == S_IDLE);

  // Classify the offered access; reserved size always faults regardless of address.
  always_comb begin
    misaligned = 1'b0;
    case (lsu_op[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = exu_data[0];
      2'b10:   misaligned = (exu_data[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it to 32 bits.
  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (op_q[1:0])
      2'b00:   load_val = op_q[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_val = op_q[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; responses only count while waiting for them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept)        state_d = misaligned ? S_DONE : S_REQ;
      S_REQ:  if (mem_req_ready) state_d = S_WAIT;
      S_WAIT: if (mem_rsp_valid) state_d = S_DONE;
      S_DONE: if (out_ready)     state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Operand capture on acceptance and load-result capture on the response cycle.
  always_comb begin
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    op_d     = op_q;
    rd_d     = rd_q;
    err_d    = err_q;
    result_d = result_q;
    if (accept) begin
      addr_d   = exu_data;
      sdata_d  = store_data;
      op_d     = lsu_op;
      rd_d     = rd_in;
      err_d    = misaligned;
      result_d = 32'h0;
    end else if ((state_q == S_WAIT) && mem_rsp_valid && !op_q[3]) begin
      result_d = load_val;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= 32'h0;
      sdata_q  <= 32'h0;
      op_q     <= 4'h0;
      rd_q     <= 5'h0;
      err_q    <= 1'b0;
      result_q <= 32'h0;
    end else begin
      addr_q   <= addr_d;
      sdata_q  <= sdata_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  // Outputs are driven from registered state only, so they cannot move while stalled.
  always_comb begin
    in_ready      = (state_q == S_IDLE);
    mem_req_valid = 1'b0;
    mem_addr      = 32'h0;
    mem_wen       = 1'b0;
    mem_wdata     = 32'h0;
    mem_wmask     = 4'b0000;
    out_valid     = 1'b0;
    out_data      = 32'h0;
    out_rd        = 5'h0;
    out_err       = 1'b0;
    if (state_q == S_REQ) begin
      mem_req_valid = 1'b1;
      mem_addr      = {addr_q[31:2], 2'b00};
      mem_wen       = op_q[3];
      if (op_q[3]) begin
        case (op_q[1:0])
          2'b00: begin
            mem_wmask = 4'b0001 << addr_q[1:0];
            mem_wdata = {4{sdata_q[7:0]}};
          end
          2'b01: begin
            mem_wmask = 4'b0011 << addr_q[1:0];
            mem_wdata = {2{sdata_q[15:0]}};
          end
          default: begin
            mem_wmask = 4'b1111;
            mem_wdata = sdata_q;
          end
        endcase
      end
    end
    if (state_q == S_DONE) begin
      out_valid = 1'b1;
      out_data  = result_q;
      out_rd    = rd_q;
      out_err   = err_q;
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] exu_data;
  logic [31:0] store_data;
  logic [3:0]  lsu_op;
  logic [4:0]  rd_in;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .exu_data(exu_data), .store_data(store_data), .lsu_op(lsu_op), .rd_in(rd_in),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_err(out_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One complete operation. Inputs change on negedges, outputs are sampled there too.
  // in_valid stays high with junk operands after acceptance to show it is ignored.
  task automatic run_op(input string nm, input logic [31:0] addr, input logic [3:0] op,
                        input logic [31:0] sdata, input logic [4:0] rd,
                        input logic [31:0] rdata, input int req_stall, input int out_stall,
                        input logic exp_err, input logic [3:0] exp_mask,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_out);
    @(negedge clk);
    chk({nm, ":in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; exu_data = addr; lsu_op = op; store_data = sdata; rd_in = rd;
    @(posedge clk);
    @(negedge clk);
    exu_data = 32'h1357_9BDF; lsu_op = 4'b1010; store_data = 32'hDEAD_BEEF; rd_in = 5'd31;
    if (!exp_err) begin
      for (int i = 0; i <= req_stall; i++) begin
        if (i != 0) @(negedge clk);
        mem_req_ready = (i == req_stall);
        // Response coinciding with the request handshake must not be taken.
        mem_rsp_valid = (i == req_stall);
        mem_rdata     = 32'hEEEE_EEEE;
        chk({nm, ":req_valid"}, 32'(mem_req_valid), 32'd1);
        chk({nm, ":in_ready_req"}, 32'(in_ready), 32'd0);
        chk({nm, ":mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({nm, ":mem_wen"}, 32'(mem_wen), 32'(op[3]));
        chk({nm, ":mem_wmask"}, 32'(mem_wmask), 32'(exp_mask));
        if (op[3]) chk({nm, ":mem_wdata"}, mem_wdata, exp_wdata);
        @(posedge clk);
      end
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk({nm, ":wait_no_out"}, 32'(out_valid), 32'd0);
      chk({nm, ":wait_no_req"}, 32'(mem_req_valid), 32'd0);
      mem_rsp_valid = 1'b1; mem_rdata = rdata;
      @(posedge clk);
      @(negedge clk);
      mem_rsp_valid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    end else begin
      chk({nm, ":err_no_req"}, 32'(mem_req_valid), 32'd0);
    end
    for (int i = 0; i <= out_stall; i++) begin
      if (i != 0) @(negedge clk);
      out_ready = (i == out_stall);
      chk({nm, ":out_valid"}, 32'(out_valid), 32'd1);
      chk({nm, ":out_data"}, out_data, exp_out);
      chk({nm, ":out_rd"}, 32'(out_rd), 32'(rd));
      chk({nm, ":out_err"}, 32'(out_err), 32'(exp_err));
      chk({nm, ":in_ready_done"}, 32'(in_ready), 32'd0);
      chk({nm, ":done_no_req"}, 32'(mem_req_valid), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    chk({nm, ":back_idle"}, 32'(in_ready), 32'd1);
    chk({nm, ":no_accept_on_consume"}, 32'(mem_req_valid | out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; exu_data = 32'h0; store_data = 32'h0; lsu_op = 4'h0;
    rd_in = 5'h0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst:in_ready", 32'(in_ready), 32'd1);
    chk("rst:req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst:out_valid", 32'(out_valid), 32'd0);
    chk("rst:out_data", out_data, 32'h0);
    chk("rst:wmask_wen", {27'h0, mem_wen, mem_wmask}, 32'h0);
    rst = 1'b0;

    //     name      addr          op       sdata         rd     rdata        rs os err mask     wdata         out
    run_op("lb_s",   32'h8000_0003, 4'b0000, 32'h0,        5'd1, 32'h8F11_2233, 0, 0, 0, 4'b0000, 32'h0,        32'hFFFF_FF8F);
    run_op("lhu",    32'h8000_0002, 4'b0101, 32'h0,        5'd2, 32'h8F11_2233, 0, 0, 0, 4'b0000, 32'h0,        32'h0000_8F11);
    run_op("lh_s",   32'h8000_0002, 4'b0001, 32'h0,        5'd3, 32'h8F11_2233, 0, 0, 0, 4'b0000, 32'h0,        32'hFFFF_8F11);
    run_op("lb_l2",  32'h8000_0002, 4'b0000, 32'h0,        5'd4, 32'h00A5_0000, 0, 0, 0, 4'b0000, 32'h0,        32'hFFFF_FFA5);
    run_op("lbu_l2", 32'h8000_0002, 4'b0100, 32'h0,        5'd5, 32'h00A5_0000, 0, 0, 0, 4'b0000, 32'h0,        32'h0000_00A5);
    run_op("lb_l1",  32'h8000_0001, 4'b0000, 32'h0,        5'd6, 32'h8F11_2233, 0, 0, 0, 4'b0000, 32'h0,        32'h0000_0022);
    run_op("lw",     32'h8000_0004, 4'b0010, 32'h0,        5'd7, 32'hCAFE_F00D, 0, 0, 0, 4'b0000, 32'h0,        32'hCAFE_F00D);
    run_op("sb",     32'h8000_0001, 4'b1000, 32'h0000_00AB, 5'd8, 32'hFFFF_FFFF, 0, 0, 0, 4'b0010, 32'hABAB_ABAB, 32'h0);
    run_op("sh",     32'h8000_0002, 4'b1001, 32'h1234_BEEF, 5'd9, 32'hFFFF_FFFF, 0, 0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    run_op("sw",     32'h8000_0008, 4'b1010, 32'h1122_3344, 5'd10, 32'hFFFF_FFFF, 0, 0, 0, 4'b1111, 32'h1122_3344, 32'h0);
    run_op("lw_mis", 32'h8000_0002, 4'b0010, 32'h0,        5'd11, 32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0);
    run_op("lh_mis", 32'h8000_0001, 4'b0001, 32'h0,        5'd12, 32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0);
    run_op("rsv_ld", 32'h8000_0000, 4'b0011, 32'h0,        5'd13, 32'h0,        0, 1, 1, 4'b0000, 32'h0,        32'h0);
    run_op("rsv_st", 32'h8000_0000, 4'b1011, 32'h1234_5678, 5'd14, 32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0);
    run_op("lb_bp",  32'h8000_0003, 4'b0000, 32'h0,        5'd15, 32'h8F11_2233, 3, 2, 0, 4'b0000, 32'h0,        32'hFFFF_FF8F);
    run_op("sh_bp",  32'h8000_0000, 4'b1001, 32'h0000_1234, 5'd16, 32'h0,        3, 2, 0, 4'b0011, 32'h1234_1234, 32'h0);

    // Reset while waiting for a response, then a stray response in IDLE.
    @(negedge clk);
    in_valid = 1'b1; exu_data = 32'h8000_0010; lsu_op = 4'b0010; rd_in = 5'd20;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rstw:in_wait", 32'(out_valid | mem_req_valid | in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h7777_7777;
    chk("rstw:idle_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("rstw:stray_out", 32'(out_valid), 32'd0);
    chk("rstw:stray_ready", 32'(in_ready), 32'd1);
    chk("rstw:stray_req", 32'(mem_req_valid), 32'd0);
    run_op("lw_after", 32'h8000_0010, 4'b0010, 32'h0, 5'd21, 32'h0BAD_F00D, 0, 0, 0, 4'b0000, 32'h0, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
